// File: rtl/vga_ctrl_640x480.sv
// VGA timing generator for 640x480 at 60 Hz.
// Free-running horizontal/vertical counters on the pixel clock drive the
// sync pulses, the active-video flag and the pixel coordinates used to read
// the combinational frame memory. The returned 24-bit pixel is split into
// R/G/B and forced to zero outside the active region.
// All outputs are decoded combinationally from the counters, so coordinates
// and the pixel returned for them belong to the same pclk cycle.
module vga_ctrl_640x480 #(
   parameter logic [9:0] H_FRONTPORCH = 10'd96,   // h_cnt at which hsync rises
   parameter logic [9:0] H_ACTIVE     = 10'd144,  // first active column count
   parameter logic [9:0] H_BACKPORCH  = 10'd784,  // first inactive count after active
   parameter logic [9:0] H_TOTAL      = 10'd800,  // counts per line
   parameter logic [9:0] V_FRONTPORCH = 10'd2,    // v_cnt at which vsync rises
   parameter logic [9:0] V_ACTIVE     = 10'd35,   // first active line
   parameter logic [9:0] V_BACKPORCH  = 10'd515,  // first inactive line after active
   parameter logic [9:0] V_TOTAL      = 10'd525   // lines per frame
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic [23:0] vga_data,
   output logic [9:0]  h_addr,
   output logic [9:0]  v_addr,
   output logic        hsync,
   output logic        vsync,
   output logic        valid,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b
);

   logic [9:0] r_h_cnt;
   logic [9:0] r_v_cnt;

   logic       w_h_wrap;
   logic       w_v_wrap;
   logic       w_h_valid;
   logic       w_v_valid;
   logic       w_valid;

   // Wrap points: end of line and last line of the frame.
   assign w_h_wrap = (r_h_cnt == (H_TOTAL - 10'd1));
   assign w_v_wrap = (r_v_cnt == (V_TOTAL - 10'd1));

   // Horizontal counter: 0..H_TOTAL-1, wraps every line.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_h_cnt <= '0;
      end else if (w_h_wrap) begin
         r_h_cnt <= '0;
      end else begin
         r_h_cnt <= r_h_cnt + 10'd1;
      end
   end

   // Vertical counter: advances only when the line ends, wraps every frame.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         r_v_cnt <= '0;
      end else if (w_h_wrap) begin
         if (w_v_wrap) begin
            r_v_cnt <= '0;
         end else begin
            r_v_cnt <= r_v_cnt + 10'd1;
         end
      end
   end

   // Active-region windows in each dimension.
   assign w_h_valid = (r_h_cnt >= H_ACTIVE) && (r_h_cnt < H_BACKPORCH);
   assign w_v_valid = (r_v_cnt >= V_ACTIVE) && (r_v_cnt < V_BACKPORCH);
   assign w_valid   = w_h_valid && w_v_valid;

   // Output decode: sync pulses, coordinates and blanked colour.
   // With the counters held at zero in reset every output naturally reads 0.
   always_comb begin
      hsync  = (r_h_cnt >= H_FRONTPORCH);
      vsync  = (r_v_cnt >= V_FRONTPORCH);
      valid  = w_valid;
      h_addr = '0;
      v_addr = '0;
      vga_r  = '0;
      vga_g  = '0;
      vga_b  = '0;
      if (w_h_valid) begin
         h_addr = r_h_cnt - H_ACTIVE;
      end
      if (w_v_valid) begin
         v_addr = r_v_cnt - V_ACTIVE;
      end
      if (w_valid) begin
         vga_r = vga_data[23:16];
         vga_g = vga_data[15:8];
         vga_b = vga_data[7:0];
      end
   end

endmodule

// File: tb/tb_vga_ctrl_640x480.sv
// Bench for vga_ctrl_640x480. A full-size instance uses the real 640x480
// timing; a second instance shrinks the frame to 20 lines so the end of the
// active region and the frame wrap are reachable in a short run. Expected
// outputs come from a time-based model: cycle index since reset release
// mapped to (column, line) with division and modulo.
module tb_vga_ctrl_640x480;

   logic        pclk = 1'b0;
   logic        reset;
   logic [23:0] vga_data;

   logic [9:0]  h_addr, v_addr;
   logic        hsync, vsync, valid;
   logic [7:0]  vga_r, vga_g, vga_b;

   logic [9:0]  s_h_addr, s_v_addr;
   logic        s_hsync, s_vsync, s_valid;
   logic [7:0]  s_vga_r, s_vga_g, s_vga_b;

   int n_checks = 0;
   int n_fail   = 0;
   int t        = 0;  // cycle index since last reset release

   localparam int SV_FP  = 2;
   localparam int SV_ACT = 5;
   localparam int SV_BP  = 15;
   localparam int SV_TOT = 20;

   vga_ctrl_640x480 dut (
      .pclk     (pclk),
      .reset    (reset),
      .vga_data (vga_data),
      .h_addr   (h_addr),
      .v_addr   (v_addr),
      .hsync    (hsync),
      .vsync    (vsync),
      .valid    (valid),
      .vga_r    (vga_r),
      .vga_g    (vga_g),
      .vga_b    (vga_b)
   );

   vga_ctrl_640x480 #(
      .V_FRONTPORCH (10'(SV_FP)),
      .V_ACTIVE     (10'(SV_ACT)),
      .V_BACKPORCH  (10'(SV_BP)),
      .V_TOTAL      (10'(SV_TOT))
   ) dut_small (
      .pclk     (pclk),
      .reset    (reset),
      .vga_data (vga_data),
      .h_addr   (s_h_addr),
      .v_addr   (s_v_addr),
      .hsync    (s_hsync),
      .vsync    (s_vsync),
      .valid    (s_valid),
      .vga_r    (s_vga_r),
      .vga_g    (s_vga_g),
      .vga_b    (s_vga_b)
   );

   // clock / reset
   always #5 pclk = ~pclk;

   // Reference: {hsync, vsync, valid, h_addr, v_addr, rgb} at cycle tt.
   function automatic logic [46:0] model(input int tt, input int vfp, input int vact,
                                         input int vbp, input int vtot, input logic [23:0] d);
      int          h, v;
      logic        hv, vv, hs, vs, val;
      logic [9:0]  ha, va;
      logic [23:0] rgb;
      h   = tt % 800;
      v   = (tt / 800) % vtot;
      hs  = (h >= 96);
      vs  = (v >= vfp);
      hv  = (h >= 144) && (h < 784);
      vv  = (v >= vact) && (v < vbp);
      val = hv && vv;
      ha  = hv ? 10'(h - 144) : 10'd0;
      va  = vv ? 10'(v - vact) : 10'd0;
      rgb = val ? d : 24'd0;
      return {hs, vs, val, ha, va, rgb};
   endfunction

   // driver tasks
   task automatic tick();
      @(posedge pclk);
      t = t + 1;
      #1 vga_data = 24'($urandom);
      #3;
   endtask

   task automatic goto_cycle(input int target);
      while (t < target) tick();
   endtask

   task automatic release_reset();
      @(posedge pclk);
      #2 reset = 1'b0;
      t = 0;
      vga_data = 24'($urandom);
      #2;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      vga_data = 24'hFFFFFF;
      repeat (3) @(posedge pclk);
      #2;
      n_checks++;
      if ({hsync, vsync, valid} !== 3'b000) begin
         n_fail++; $display("FAIL reset_sync_valid got=%b exp=000", {hsync, vsync, valid});
      end
      n_checks++;
      if ({h_addr, v_addr} !== 20'd0) begin
         n_fail++; $display("FAIL reset_addr got h=%0d v=%0d exp 0/0", h_addr, v_addr);
      end
      n_checks++;
      if ({vga_r, vga_g, vga_b} !== 24'd0) begin
         n_fail++; $display("FAIL reset_rgb got=%h exp=000000", {vga_r, vga_g, vga_b});
      end
      n_checks++;
      if ({s_hsync, s_vsync, s_valid, s_h_addr, s_v_addr, s_vga_r, s_vga_g, s_vga_b} !== 47'd0) begin
         n_fail++; $display("FAIL reset_small_outputs got nonzero exp all 0");
      end
      release_reset();
      n_checks++;
      if ({hsync, vsync, valid, h_addr} !== 13'd0) begin
         n_fail++; $display("FAIL first_cycle_after_release got hs=%b vs=%b val=%b h=%0d exp 0",
                            hsync, vsync, valid, h_addr);
      end
   endtask

   task automatic test_vsync();
      int   lo_b = 0;
      int   lo_s = 0;
      int   rise_s = -1;
      logic [2:0] last_s = 3'bxxx;
      while (t < 16000) begin
         if (!vsync) lo_b++;
         if (!s_vsync) lo_s++;
         if (s_vsync && rise_s < 0) rise_s = t;
         if (t == 15999) last_s = {s_hsync, s_vsync, s_valid};
         tick();
      end
      n_checks++;
      if (lo_b !== 1600) begin
         n_fail++; $display("FAIL vsync_low_len got=%0d exp=1600", lo_b);
      end
      n_checks++;
      if (vsync !== 1'b1) begin
         n_fail++; $display("FAIL vsync_high_after_2_lines got=%b exp=1", vsync);
      end
      n_checks++;
      if (lo_s !== 1600 || rise_s !== 1600) begin
         n_fail++; $display("FAIL small_vsync_frame got low=%0d rise=%0d exp 1600/1600", lo_s, rise_s);
      end
      n_checks++;
      if (last_s !== 3'b110) begin
         n_fail++; $display("FAIL small_last_cycle got hs,vs,val=%b exp=110", last_s);
      end
      n_checks++;
      if ({s_hsync, s_vsync, s_valid, s_h_addr, s_v_addr} !== 23'd0) begin
         n_fail++; $display("FAIL small_frame_wrap got hs=%b vs=%b val=%b h=%0d v=%0d exp all 0",
                            s_hsync, s_vsync, s_valid, s_h_addr, s_v_addr);
      end
   endtask

   task automatic test_hsync();
      int lo = 0;
      int rise = -1;
      logic at799, at800;
      goto_cycle(16800);
      while (t < 18400) begin
         if (!hsync) lo++;
         if (hsync && rise < 0) rise = t - 16800;
         if (t == 16800 + 799) at799 = hsync;
         if (t == 16800 + 800) at800 = hsync;
         tick();
      end
      n_checks++;
      if (lo !== 192) begin
         n_fail++; $display("FAIL hsync_low_two_lines got=%0d exp=192", lo);
      end
      n_checks++;
      if (rise !== 96) begin
         n_fail++; $display("FAIL hsync_rise_offset got=%0d exp=96", rise);
      end
      n_checks++;
      if ({at799, at800} !== 2'b10) begin
         n_fail++; $display("FAIL hsync_period got 799:%b 800:%b exp 1/0", at799, at800);
      end
   endtask

   task automatic test_v_edges();
      goto_cycle(14 * 800 + 16000 + 144);
      n_checks++;
      if ({s_valid, s_v_addr, s_h_addr} !== {1'b1, 10'd9, 10'd0}) begin
         n_fail++; $display("FAIL small_last_active_line got val=%b v=%0d h=%0d exp 1/9/0",
                            s_valid, s_v_addr, s_h_addr);
      end
      n_checks++;
      if (valid !== 1'b0) begin
         n_fail++; $display("FAIL line34_not_active got=%b exp=0", valid);
      end
      goto_cycle(14 * 800 + 16000 + 783);
      n_checks++;
      if ({s_valid, s_h_addr, s_v_addr} !== {1'b1, 10'd639, 10'd9}) begin
         n_fail++; $display("FAIL small_last_pixel got val=%b h=%0d v=%0d exp 1/639/9",
                            s_valid, s_h_addr, s_v_addr);
      end
      n_checks++;
      if ({s_vga_r, s_vga_g, s_vga_b} !== vga_data) begin
         n_fail++; $display("FAIL small_last_pixel_rgb got=%h exp=%h", {s_vga_r, s_vga_g, s_vga_b}, vga_data);
      end
   endtask

   task automatic test_first_pixel();
      goto_cycle(28143);
      n_checks++;
      if (valid !== 1'b0) begin
         n_fail++; $display("FAIL before_first_pixel got=%b exp=0", valid);
      end
      tick();
      vga_data = 24'hA1B2C3;
      #1;
      n_checks++;
      if ({valid, h_addr, v_addr} !== {1'b1, 10'd0, 10'd0}) begin
         n_fail++; $display("FAIL first_pixel got val=%b h=%0d v=%0d exp 1/0/0", valid, h_addr, v_addr);
      end
      n_checks++;
      if ({vga_r, vga_g, vga_b} !== 24'hA1B2C3) begin
         n_fail++; $display("FAIL first_pixel_rgb got=%h%h%h exp=a1b2c3", vga_r, vga_g, vga_b);
      end
      n_checks++;
      if ({s_valid, s_v_addr, s_vga_r} !== 19'd0) begin
         n_fail++; $display("FAIL small_line15_inactive got val=%b v=%0d r=%h exp 0", s_valid, s_v_addr, s_vga_r);
      end
      goto_cycle(28144 + 639);
      n_checks++;
      if ({valid, h_addr, v_addr} !== {1'b1, 10'd639, 10'd0}) begin
         n_fail++; $display("FAIL last_active_column got val=%b h=%0d v=%0d exp 1/639/0", valid, h_addr, v_addr);
      end
      tick();
      vga_data = 24'hFFFFFF;
      #1;
      n_checks++;
      if ({valid, h_addr, vga_r, vga_g, vga_b} !== 35'd0) begin
         n_fail++; $display("FAIL first_inactive_column got val=%b h=%0d rgb=%h%h%h exp 0",
                            valid, h_addr, vga_r, vga_g, vga_b);
      end
   endtask

   task automatic test_async_reset();
      goto_cycle(36 * 800 + 500);
      n_checks++;
      if ({valid, h_addr, v_addr} !== {1'b1, 10'd356, 10'd1}) begin
         n_fail++; $display("FAIL pre_reset_position got val=%b h=%0d v=%0d exp 1/356/1", valid, h_addr, v_addr);
      end
      vga_data = 24'hFFFFFF;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({hsync, vsync, valid, h_addr, v_addr, vga_r, vga_g, vga_b} !== 47'd0) begin
         n_fail++; $display("FAIL async_reset got hs=%b vs=%b val=%b h=%0d v=%0d rgb=%h%h%h exp all 0",
                            hsync, vsync, valid, h_addr, v_addr, vga_r, vga_g, vga_b);
      end
      repeat (2) @(posedge pclk);
      release_reset();
      n_checks++;
      if ({hsync, vsync, valid, h_addr, v_addr} !== 23'd0) begin
         n_fail++; $display("FAIL restart_after_reset got nonzero exp all 0");
      end
   endtask

   task automatic test_random_scan();
      logic [46:0] exp_b, exp_s, got_b, got_s;
      int fails_here = 0;
      while (t < 3000 && fails_here < 10) begin
         exp_b = model(t, 2, 35, 515, 525, vga_data);
         exp_s = model(t, SV_FP, SV_ACT, SV_BP, SV_TOT, vga_data);
         got_b = {hsync, vsync, valid, h_addr, v_addr, vga_r, vga_g, vga_b};
         got_s = {s_hsync, s_vsync, s_valid, s_h_addr, s_v_addr, s_vga_r, s_vga_g, s_vga_b};
         n_checks++;
         if (got_b !== exp_b) begin
            n_fail++; fails_here++;
            $display("FAIL scan_full t=%0d got=%h exp=%h", t, got_b, exp_b);
         end
         n_checks++;
         if (got_s !== exp_s) begin
            n_fail++; fails_here++;
            $display("FAIL scan_small t=%0d got=%h exp=%h", t, got_s, exp_s);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_vsync();
      test_hsync();
      test_v_edges();
      test_first_pixel();
      test_async_reset();
      test_random_scan();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
